// File: rtl/rl_ram_1r1w_fifo_ctrl_if.sv
// FIFO controller bundle: user push/pop side and RAM port side.
// slave = controller, master = user/RAM environment.
interface rl_ram_1r1w_fifo_ctrl_if #(
  parameter int ABITS = 10,
  parameter int DBITS = 32
);
  logic                     clr_i;
  logic                     push_i;
  logic [DBITS-1:0]         din_i;
  logic                     pop_i;
  logic [DBITS-1:0]         dout_o;
  logic                     rvalid_o;
  logic                     full_o;
  logic                     empty_o;
  logic                     almost_full_o;
  logic [ABITS:0]           count_o;
  logic                     overflow_o;
  logic                     underflow_o;
  logic [ABITS-1:0]         ram_waddr_o;
  logic [DBITS-1:0]         ram_din_o;
  logic                     ram_we_o;
  logic [(DBITS+7)/8-1:0]   ram_be_o;
  logic [ABITS-1:0]         ram_raddr_o;
  logic                     ram_re_o;
  logic [DBITS-1:0]         ram_dout_i;

  modport slave (
    input  clr_i, push_i, din_i, pop_i, ram_dout_i,
    output dout_o, rvalid_o, full_o, empty_o, almost_full_o,
    output count_o, overflow_o, underflow_o,
    output ram_waddr_o, ram_din_o, ram_we_o, ram_be_o,
    output ram_raddr_o, ram_re_o
  );

  modport master (
    output clr_i, push_i, din_i, pop_i, ram_dout_i,
    input  dout_o, rvalid_o, full_o, empty_o, almost_full_o,
    input  count_o, overflow_o, underflow_o,
    input  ram_waddr_o, ram_din_o, ram_we_o, ram_be_o,
    input  ram_raddr_o, ram_re_o
  );
endinterface

// File: rtl/rl_ram_1r1w_fifo_ctrl.sv
// Synchronous FIFO controller driving an external 1R1W RAM.
// Optional RL_FIFO_ERRCHK_EN: sticky overflow/underflow + assertions.
module rl_ram_1r1w_fifo_ctrl #(
  parameter int ABITS     = 10,
  parameter int DBITS     = 32,
  parameter int AFULL_LVL = (1 << ABITS) - 4
) (
  input logic clk_i,
  input logic rst_i,
  rl_ram_1r1w_fifo_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << ABITS;
  localparam logic [ABITS:0] DEPTH_C = (ABITS+1)'(DEPTH);
  localparam logic [ABITS:0] AFULL_C = (ABITS+1)'(AFULL_LVL);

  logic [ABITS-1:0] wptr_d, wptr_q;
  logic [ABITS-1:0] rptr_d, rptr_q;
  logic [ABITS:0]   cnt_d, cnt_q;
  logic             full_d, full_q;
  logic             empty_d, empty_q;
  logic             afull_d, afull_q;
  logic             rvalid_d, rvalid_q;
  logic             kill, push_ok, pop_ok;

  // Request qualification and next-state pointers, count and flags
  always_comb begin
    kill     = rst_i | bus.clr_i;
    push_ok  = bus.push_i & ~full_q & ~kill;
    pop_ok   = bus.pop_i & ~empty_q & ~kill;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;
    rvalid_d = pop_ok;
    if (kill) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
    full_d  = (cnt_d == DEPTH_C);
    empty_d = (cnt_d == '0);
    afull_d = (cnt_d >= AFULL_C);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.ram_we_o      = push_ok;
  assign bus.ram_re_o      = pop_ok;
  assign bus.ram_waddr_o   = wptr_q;
  assign bus.ram_raddr_o   = rptr_q;
  assign bus.ram_din_o     = bus.din_i;
  assign bus.ram_be_o      = '1;
  assign bus.dout_o        = bus.ram_dout_i;
  assign bus.rvalid_o      = rvalid_q;
  assign bus.full_o        = full_q;
  assign bus.empty_o       = empty_q;
  assign bus.almost_full_o = afull_q;
  assign bus.count_o       = cnt_q;

`ifdef RL_FIFO_ERRCHK_EN
  logic ovf_d, ovf_q;
  logic unf_d, unf_q;

  // Sticky error flags: survive a flush, cleared only by reset
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (!bus.clr_i) begin
      ovf_d = ovf_q | (bus.push_i & full_q);
      unf_d = unf_q | (bus.pop_i & empty_q);
    end
  end

  // Error flag registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.overflow_o  = ovf_q;
  assign bus.underflow_o = unf_q;

  a_cnt_range: assert property (
    @(posedge clk_i) disable iff (rst_i) cnt_q <= DEPTH_C);
  a_no_same_addr: assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(bus.ram_we_o && bus.ram_re_o &&
      (bus.ram_waddr_o == bus.ram_raddr_o)));
`else
  assign bus.overflow_o  = 1'b0;
  assign bus.underflow_o = 1'b0;
`endif
endmodule

// File: tb/tb_rl_ram_1r1w_fifo_ctrl.sv
// Randomized scoreboard bench for rl_ram_1r1w_fifo_ctrl.
// Reference model is a plain queue of FIFO contents.
module tb_rl_ram_1r1w_fifo_ctrl;
  localparam int AB = 2;
  localparam int DB = 8;
  localparam int DEP = 4;
  localparam int AFL = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails = 0;
  bit   mon_en = 0;

  logic [DB-1:0] model_q[$];
  logic [DB-1:0] exp_q[$];
  bit            m_ovf = 0;
  bit            m_unf = 0;
  logic [DB-1:0] mem [DEP];

  rl_ram_1r1w_fifo_ctrl_if #(.ABITS(AB), .DBITS(DB)) bus ();

  rl_ram_1r1w_fifo_ctrl #(
    .ABITS(AB), .DBITS(DB), .AFULL_LVL(AFL)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Generic RAM: registered read, one-cycle latency
  always @(posedge clk) begin
    if (bus.ram_we_o) mem[bus.ram_waddr_o] <= bus.ram_din_o;
    if (bus.ram_re_o) bus.ram_dout_i <= mem[bus.ram_raddr_o];
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: each read expectation must appear exactly one cycle later
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        logic [DB-1:0] e;
        e = exp_q.pop_front();
        check("rvalid", int'(bus.rvalid_o), 1);
        check("dout", int'(bus.dout_o), int'(e));
      end else begin
        check("no_rvalid", int'(bus.rvalid_o), 0);
      end
    end
  end

  task automatic step(input bit p, input logic [DB-1:0] d,
                      input bit q, input bit c, input bit r);
    bit pok, qok;
    int sz;
    rst = r;
    bus.clr_i = c;
    bus.push_i = p;
    bus.din_i = d;
    bus.pop_i = q;
    #1;
    sz = model_q.size();
    pok = p && sz < DEP && !r && !c;
    qok = q && sz > 0 && !r && !c;
    if (mon_en) begin
      check("ram_we", int'(bus.ram_we_o), int'(pok));
      check("ram_re", int'(bus.ram_re_o), int'(qok));
      check("ram_be", int'(bus.ram_be_o), 1);
    end
    if (qok) exp_q.push_back(model_q[0]);
    if (r) begin
      m_ovf = 0;
      m_unf = 0;
    end else if (!c) begin
      if (p && sz == DEP) m_ovf = 1;
      if (q && sz == 0) m_unf = 1;
    end
    if (r || c) model_q.delete();
    else begin
      if (qok) void'(model_q.pop_front());
      if (pok) model_q.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    sz = model_q.size();
    check("count", int'(bus.count_o), sz);
    check("full", int'(bus.full_o), int'(sz == DEP));
    check("empty", int'(bus.empty_o), int'(sz == 0));
    check("afull", int'(bus.almost_full_o), int'(sz >= AFL));
`ifdef RL_FIFO_ERRCHK_EN
    check("ovf", int'(bus.overflow_o), int'(m_ovf));
    check("unf", int'(bus.underflow_o), int'(m_unf));
`else
    check("ovf", int'(bus.overflow_o), 0);
    check("unf", int'(bus.underflow_o), 0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    bus.clr_i = 1'b0;
    bus.push_i = 1'b0;
    bus.pop_i = 1'b0;
    bus.din_i = '0;
    @(negedge clk);
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    mon_en = 1;
    step(0, 8'h00, 0, 0, 0);
    check("rst_rvalid", int'(bus.rvalid_o), 0);

    // Fill and drain
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    check("afull_lo", int'(bus.almost_full_o), 0);
    step(1, 8'h33, 0, 0, 0);
    check("afull_hi", int'(bus.almost_full_o), 1);
    step(1, 8'h44, 0, 0, 0);
    check("full_cnt", int'(bus.count_o), 4);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    check("drained", int'(bus.empty_o), 1);

    // Full guard: pop returns 0x11, 0x55 dropped
    for (int i = 1; i <= 4; i++) step(1, 8'(i * 17), 0, 0, 0);
    step(1, 8'h55, 1, 0, 0);
    check("fullguard_cnt", int'(bus.count_o), 3);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0);
    // Empty guard: no rvalid, then 0x66 comes out
    step(1, 8'h66, 1, 0, 0);
    check("emptyguard_cnt", int'(bus.count_o), 1);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Wrap: interleaved pairs
    step(1, 8'h00, 0, 0, 0);
    for (int i = 1; i < 10; i++) step(1, 8'(i), 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Flush mid-operation, after an overflow
    for (int i = 0; i < 4; i++) step(1, 8'(8'hA0 + i), 0, 0, 0);
    step(1, 8'hEE, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    check("pre_flush", int'(bus.count_o), 3);
    step(0, 8'h00, 1, 1, 0);
    check("flush_rvalid", int'(bus.rvalid_o), 0);
    step(0, 8'h00, 0, 0, 1);

    // Random traffic with occasional flush/reset
    for (int i = 0; i < 400; i++) begin
      bit r, c;
      r = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 39) == 0);
      step(bit'($urandom_range(0, 99) < 55), 8'($urandom),
           bit'($urandom_range(0, 99) < 50), c, r);
    end

    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    check("exp_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
